alu_cmd_driver: RTL and testbench

Initiator side of the team's registered 2-bit-select ALU interface (dataA, dataB, sel in; registered dataC out). It accepts operation commands over a valid/ready handshake and drives the ALU operand and select lines from registers. It waits the ALU's fixed pipeline latency, captures dataC, and returns it as a response over a second valid/ready handshake. It keeps one operation in flight and maintains a completed-operation counter.

---
 rtl/alu_cmd_driver.sv | 102 ++++++++++
 tb/tb_alu_cmd_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command-side driver for the registered 2-bit-select ALU: one operation in flight,
// operands held in registers, result captured after the ALU pipeline latency.
module alu_cmd_driver #(
  parameter int NB_DATA  = 16,
  parameter int LATENCY  = 1,
  parameter int NB_COUNT = 16
) (
  input  logic                clock,
  input  logic                i_reset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [NB_DATA-1:0]  i_cmd_a,
  input  logic [NB_DATA-1:0]  i_cmd_b,
  input  logic [1:0]          i_cmd_op,
  output logic [NB_DATA-1:0]  o_alu_dataA,
  output logic [NB_DATA-1:0]  o_alu_dataB,
  output logic [1:0]          o_alu_sel,
  input  logic [NB_DATA-1:0]  i_alu_dataC,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [NB_DATA-1:0]  o_rsp_data,
  output logic [1:0]          o_rsp_op,
  output logic                o_rsp_zero,
  output logic [NB_COUNT-1:0] o_rsp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } stateType;

  stateType   state;
  stateType   nextState;
  logic [2:0] waitCount;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (i_cmd_valid) nextState = WAIT;
      WAIT:    if (waitCount == 3'd0) nextState = RESP;
      RESP:    if (i_rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign o_cmd_ready = (state == IDLE);

  // Operand select doubles as the op latch: it is held untouched until the next accept.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_alu_dataA <= '0;
      o_alu_dataB <= '0;
      o_alu_sel   <= 2'b00;
      waitCount   <= 3'd0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_op    <= 2'b00;
      o_rsp_zero  <= 1'b0;
      o_rsp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_alu_dataA <= i_cmd_a;
            o_alu_dataB <= i_cmd_b;
            o_alu_sel   <= i_cmd_op;
            waitCount   <= 3'(LATENCY);
          end
        end
        WAIT: begin
          if (waitCount != 3'd0) begin
            waitCount <= waitCount - 3'd1;
          end else begin
            o_rsp_data  <= i_alu_dataC;
            o_rsp_zero  <= (i_alu_dataC == '0);
            o_rsp_op    <= o_alu_sel;
            o_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_count <= o_rsp_count + {{(NB_COUNT-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver with a one-stage registered ALU; vector table, random ops
// against an arithmetic reference, plus backpressure, mid-flight reset and counter wrap.
module tb_alu_cmd_driver;

  localparam int NB_DATA  = 16;
  localparam int LATENCY  = 1;
  localparam int NB_COUNT = 4;

  logic                clock = 1'b0;
  logic                resetN;
  logic                cmdValid;
  logic                cmdReady;
  logic [NB_DATA-1:0]  cmdA;
  logic [NB_DATA-1:0]  cmdB;
  logic [1:0]          cmdOp;
  logic [NB_DATA-1:0]  aluDataA;
  logic [NB_DATA-1:0]  aluDataB;
  logic [1:0]          aluSel;
  logic [NB_DATA-1:0]  aluDataC = '0;
  logic                rspValid;
  logic                rspReady;
  logic [NB_DATA-1:0]  rspData;
  logic [1:0]          rspOp;
  logic                rspZero;
  logic [NB_COUNT-1:0] rspCount;

  int checks = 0;
  int errors = 0;
  int modelCount = 0;

  alu_cmd_driver #(
    .NB_DATA(NB_DATA), .LATENCY(LATENCY), .NB_COUNT(NB_COUNT)
  ) dut (
    .clock(clock), .i_reset_n(resetN),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
    .i_cmd_a(cmdA), .i_cmd_b(cmdB), .i_cmd_op(cmdOp),
    .o_alu_dataA(aluDataA), .o_alu_dataB(aluDataB), .o_alu_sel(aluSel),
    .i_alu_dataC(aluDataC),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_data(rspData), .o_rsp_op(rspOp), .o_rsp_zero(rspZero),
    .o_rsp_count(rspCount)
  );

  always #5 clock = ~clock;

  // Team ALU: one register stage on the result.
  always_ff @(posedge clock) begin
    case (aluSel)
      2'b00:   aluDataC <= aluDataA + aluDataB;
      2'b01:   aluDataC <= aluDataA - aluDataB;
      2'b10:   aluDataC <= aluDataA & aluDataB;
      default: aluDataC <= aluDataA | aluDataB;
    endcase
  end

  function automatic logic [15:0] refResult(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b + 65536;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return 16'(r % 65536);
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] expData;
    logic        expZero;
  } vecType;

  vecType vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Entered right after the accept edge's falling edge; waits for the response and completes it.
  task automatic waitAndCheck(input string name, input logic [15:0] expData, input logic [1:0] expOp);
    int n;
    n = 1;
    while (!rspValid && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, " latency"}, 32'(n), 32'(LATENCY + 2));
    checkOutput({name, " data"}, 32'(rspData), 32'(expData));
    checkOutput({name, " op"}, 32'(rspOp), 32'(expOp));
    checkOutput({name, " zero"}, 32'(rspZero), 32'(expData == 16'h0000));
    rspReady = 1'b1;
    @(negedge clock);
    modelCount = (modelCount + 1) % (1 << NB_COUNT);
    checkOutput({name, " valid cleared"}, 32'(rspValid), 32'd0);
    checkOutput({name, " count"}, 32'(rspCount), 32'(modelCount));
    checkOutput({name, " cmd ready"}, 32'(cmdReady), 32'd1);
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic [1:0] op, input logic [15:0] expData);
    cmdValid = 1'b1;
    cmdA = a;
    cmdB = b;
    cmdOp = op;
    checkOutput({name, " ready before accept"}, 32'(cmdReady), 32'd1);
    @(posedge clock);
    @(negedge clock);
    cmdValid = 1'b0;
    checkOutput({name, " aluA"}, 32'(aluDataA), 32'(a));
    checkOutput({name, " aluB"}, 32'(aluDataB), 32'(b));
    checkOutput({name, " aluSel"}, 32'(aluSel), 32'(op));
    checkOutput({name, " busy"}, 32'(cmdReady), 32'd0);
    waitAndCheck(name, expData, op);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rop;

    vecs[0] = '{16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h1234, 16'h0000, 2'b10, 16'h0000, 1'b1};
    vecs[3] = '{16'h00F0, 16'h000F, 2'b11, 16'h00FF, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 2'b01, 16'h0000, 1'b1};
    vecs[6] = '{16'hA5A5, 16'h5A5A, 2'b11, 16'hFFFF, 1'b0};

    resetN = 1'b0;
    cmdValid = 1'b0;
    cmdA = '0;
    cmdB = '0;
    cmdOp = 2'b00;
    rspReady = 1'b1;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    checkOutput("reset cmd ready", 32'(cmdReady), 32'd1);
    checkOutput("reset aluA", 32'(aluDataA), 32'd0);
    checkOutput("reset aluSel", 32'(aluSel), 32'd0);
    checkOutput("reset rsp data", 32'(rspData), 32'd0);
    checkOutput("reset rsp zero", 32'(rspZero), 32'd0);
    checkOutput("reset count", 32'(rspCount), 32'd0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle rsp valid", 32'(rspValid), 32'd0);
      @(negedge clock);
    end

    for (int i = 0; i < 7; i++) begin
      checkOutput("table zero flag", 32'(vecs[i].expZero), 32'(vecs[i].expData == 16'h0000));
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].expData);
    end

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      applyStimulus($sformatf("rand%0d", i), ra, rb, rop, refResult(int'(ra), int'(rb), int'(rop)));
    end

    // Backpressure with a second command waiting.
    rspReady = 1'b0;
    cmdValid = 1'b1;
    cmdA = 16'h0101;
    cmdB = 16'h0202;
    cmdOp = 2'b00;
    @(posedge clock);
    @(negedge clock);
    cmdA = 16'h0F0F;
    cmdB = 16'h00FF;
    cmdOp = 2'b01;
    begin
      int n;
      n = 1;
      while (!rspValid && n < 20) begin
        @(negedge clock);
        n++;
      end
      checkOutput("bp latency", 32'(n), 32'(LATENCY + 2));
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp data held", 32'(rspData), 32'h0303);
      checkOutput("bp valid held", 32'(rspValid), 32'd1);
      checkOutput("bp cmd blocked", 32'(cmdReady), 32'd0);
      checkOutput("bp operands held", 32'(aluDataA), 32'h0101);
      @(negedge clock);
    end
    rspReady = 1'b1;
    @(negedge clock);
    modelCount = (modelCount + 1) % (1 << NB_COUNT);
    checkOutput("bp count", 32'(rspCount), 32'(modelCount));
    checkOutput("bp valid cleared", 32'(rspValid), 32'd0);
    checkOutput("bp second not yet taken", 32'(aluDataA), 32'h0101);
    @(posedge clock);
    @(negedge clock);
    cmdValid = 1'b0;
    checkOutput("bp second aluA", 32'(aluDataA), 32'h0F0F);
    waitAndCheck("bp second", 16'h0E10, 2'b01);

    // Reset while the operation is in WAIT.
    cmdValid = 1'b1;
    cmdA = 16'h00F0;
    cmdB = 16'h000F;
    cmdOp = 2'b11;
    @(posedge clock);
    @(negedge clock);
    cmdValid = 1'b0;
    resetN = 1'b0;
    #1;
    checkOutput("midreset aluA", 32'(aluDataA), 32'd0);
    checkOutput("midreset aluSel", 32'(aluSel), 32'd0);
    checkOutput("midreset rsp valid", 32'(rspValid), 32'd0);
    checkOutput("midreset rsp data", 32'(rspData), 32'd0);
    checkOutput("midreset count", 32'(rspCount), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    modelCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkOutput("post reset no rsp", 32'(rspValid), 32'd0);
      checkOutput("post reset count", 32'(rspCount), 32'd0);
    end

    // Sixteen completions walk the 4-bit counter through 1..15 and back to 0.
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      applyStimulus($sformatf("wrap%0d", i), ra, rb, rop, refResult(int'(ra), int'(rb), int'(rop)));
    end
    checkOutput("wrap final count", 32'(rspCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
